m_axil_master: RTL and testbench



---
 rtl/m_axil_pkg.sv | 10 +
 rtl/axil_timeout_cnt.sv | 18 +
 rtl/m_axil_master.sv | 156 +++++++++++++++
 tb/tb_m_axil_master.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/m_axil_pkg.sv
// m_axil_pkg: shared state encoding, response codes and default widths for the AXI4-Lite master.
package m_axil_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_e;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;
  localparam int ADDR_W      = 6;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_DEF = 256;
endpackage

// File: rtl/axil_timeout_cnt.sv
// axil_timeout_cnt: response-wait counter; expired_o rises CYCLES-1 cycles after clear_i drops.
module axil_timeout_cnt #(
  parameter int CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic clear_i,
  output logic expired_o
);
  localparam int W = $clog2(CYCLES) + 1;
  logic [W-1:0] cnt_q;
  assign expired_o = cnt_q == W'(CYCLES - 1);
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) cnt_q <= '0;
    else if (enable_i && !expired_o) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/m_axil_master.sv
// m_axil_master: single-outstanding command/response to AXI4-Lite master bridge.
// Optional response-wait timeout and sticky TIMEOUT_ERR port with M_AXIL_TIMEOUT_EN.
import m_axil_pkg::*;
module m_axil_master #(
  parameter int M_AXI_ADDR_WIDTH = ADDR_W,
  parameter int M_AXI_DATA_WIDTH = DATA_W,
  parameter int TIMEOUT_CYCLES   = TIMEOUT_DEF
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          CMD_VALID,
  output logic                          CMD_READY,
  input  logic                          CMD_WRITE,
  input  logic [M_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [M_AXI_DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [M_AXI_DATA_WIDTH/8-1:0] CMD_WSTRB,
  output logic                          RSP_VALID,
  input  logic                          RSP_READY,
  output logic [M_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]                    RSP_RESP,
  output logic [M_AXI_ADDR_WIDTH-1:0]   AWADDR,
  output logic                          AWVALID,
  input  logic                          AWREADY,
  output logic [M_AXI_DATA_WIDTH-1:0]   WDATA,
  output logic [M_AXI_DATA_WIDTH/8-1:0] WSTRB,
  output logic                          WVALID,
  input  logic                          WREADY,
  input  logic [1:0]                    BRESP,
  input  logic                          BVALID,
  output logic                          BREADY,
  output logic [M_AXI_ADDR_WIDTH-1:0]   ARADDR,
  output logic                          ARVALID,
  input  logic                          ARREADY,
  input  logic [M_AXI_DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]                    RRESP,
  input  logic                          RVALID,
`ifdef M_AXIL_TIMEOUT_EN
  output logic                          TIMEOUT_ERR,
`endif
  output logic                          RREADY
);
  state_e                          state_q;
  logic [M_AXI_ADDR_WIDTH-1:0]     addr_q;
  logic [M_AXI_DATA_WIDTH-1:0]     wdata_q, rsp_rdata_q;
  logic [M_AXI_DATA_WIDTH/8-1:0]   wstrb_q;
  logic [1:0]                      rsp_resp_q;
  logic cmd_ready_q, awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, rsp_valid_q;
`ifdef M_AXIL_TIMEOUT_EN
  logic expired, timeout_err_q;
  axil_timeout_cnt #(.CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk_i(ACLK), .rst_ni(ARESETN), .enable_i(bready_q | rready_q),
    .clear_i(!(bready_q | rready_q)), .expired_o(expired)
  );
  assign TIMEOUT_ERR = timeout_err_q;
`endif
  assign CMD_READY = cmd_ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_RESP  = rsp_resp_q;
  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign AWVALID   = awvalid_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef M_AXIL_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (CMD_VALID) begin
          addr_q      <= CMD_ADDR;
          wdata_q     <= CMD_WDATA;
          wstrb_q     <= CMD_WSTRB;
          cmd_ready_q <= 1'b0;
          awvalid_q   <= CMD_WRITE;
          wvalid_q    <= CMD_WRITE;
          arvalid_q   <= !CMD_WRITE;
          state_q     <= CMD_WRITE ? WR_REQ : RD_REQ;
        end
        WR_REQ: begin
          // each VALID retires on its own handshake; the phase ends once both have
          if (awvalid_q && AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q && WREADY) wvalid_q <= 1'b0;
          if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY)) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: if (BVALID) begin
          rsp_resp_q  <= BRESP;
          rsp_rdata_q <= '0;
          bready_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
`ifdef M_AXIL_TIMEOUT_EN
        else if (expired) begin
          rsp_resp_q    <= RESP_TIMEOUT;
          rsp_rdata_q   <= '0;
          bready_q      <= 1'b0;
          rsp_valid_q   <= 1'b1;
          timeout_err_q <= 1'b1;
          state_q       <= RSP;
        end
`endif
        RD_REQ: if (ARREADY) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= RD_DATA;
        end
        RD_DATA: if (RVALID) begin
          rsp_resp_q  <= RRESP;
          rsp_rdata_q <= RDATA;
          rready_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
`ifdef M_AXIL_TIMEOUT_EN
        else if (expired) begin
          rsp_resp_q    <= RESP_TIMEOUT;
          rsp_rdata_q   <= '0;
          rready_q      <= 1'b0;
          rsp_valid_q   <= 1'b1;
          timeout_err_q <= 1'b1;
          state_q       <= RSP;
        end
`endif
        RSP: if (RSP_READY) begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m_axil_master.sv
// tb_m_axil_master: directed and random command traffic against a behavioural AXI4-Lite register slave.
module tb_m_axil_master;
  logic ACLK = 1'b0, ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;
  logic CMD_VALID = 1'b0, CMD_WRITE = 1'b0, RSP_READY = 1'b0;
  logic [5:0] CMD_ADDR = '0;
  logic [31:0] CMD_WDATA = '0;
  logic [3:0] CMD_WSTRB = '0;
  logic CMD_READY, RSP_VALID, AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] RSP_RDATA, WDATA, RDATA;
  logic [1:0] RSP_RESP, BRESP, RRESP;
  logic [5:0] AWADDR, ARADDR;
  logic [3:0] WSTRB;
`ifdef M_AXIL_TIMEOUT_EN
  logic TIMEOUT_ERR;
`endif

  m_axil_master #(.TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID),
`ifdef M_AXIL_TIMEOUT_EN
    .TIMEOUT_ERR(TIMEOUT_ERR),
`endif
    .RREADY(RREADY)
  );

  // slave: 16-word register file, programmable READY stalls, responses one cycle after the request
  logic [31:0] mem [16];
  int aw_dly = 0, w_dly = 0, aw_cnt = 0, w_cnt = 0, aw_hs = 0, w_hs = 0;
  bit b_en = 1'b1, r_en = 1'b1, aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0, stab_bad = 1'b0;
  logic [1:0] slv_resp = 2'b00;
  logic [5:0] aw_addr_s, exp_addr;
  logic [31:0] w_data_s, r_buf, exp_wdata;
  logic [3:0] w_strb_s, exp_strb;
  assign AWREADY = AWVALID && aw_cnt >= aw_dly;
  assign WREADY  = WVALID && w_cnt >= w_dly;
  assign ARREADY = ARVALID;
  assign BRESP   = slv_resp;
  assign RRESP   = slv_resp;
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  always @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      b_pend <= 1'b0; r_pend <= 1'b0; BVALID <= 1'b0; RVALID <= 1'b0; RDATA <= '0;
    end else begin
      automatic bit a = aw_got || (AWVALID && AWREADY);
      automatic bit w = w_got || (WVALID && WREADY);
      automatic logic [5:0] ad = aw_got ? aw_addr_s : AWADDR;
      automatic logic [31:0] wd = w_got ? w_data_s : WDATA;
      automatic logic [3:0] ws = w_got ? w_strb_s : WSTRB;
      automatic logic [31:0] m = mem[ad[5:2]];
      if (AWVALID && !AWREADY) aw_cnt <= aw_cnt + 1;
      if (WVALID && !WREADY) w_cnt <= w_cnt + 1;
      if (AWVALID && AWREADY) begin aw_cnt <= 0; aw_hs <= aw_hs + 1; aw_addr_s <= AWADDR; end
      if (WVALID && WREADY) begin w_cnt <= 0; w_hs <= w_hs + 1; w_data_s <= WDATA; w_strb_s <= WSTRB; end
      if (a && w) begin
        for (int b = 0; b < 4; b++) if (ws[b]) m[8*b +: 8] = wd[8*b +: 8];
        mem[ad[5:2]] <= m;
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1;
      end else begin
        aw_got <= a; w_got <= w;
      end
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (b_pend && b_en) begin BVALID <= 1'b1; b_pend <= 1'b0; end
      if (ARVALID && ARREADY) begin r_pend <= 1'b1; r_buf <= mem[ARADDR[5:2]]; end
      if (RVALID && RREADY) RVALID <= 1'b0;
      if (r_pend && r_en) begin RVALID <= 1'b1; RDATA <= r_buf; r_pend <= 1'b0; end
      if (AWVALID && AWADDR !== exp_addr) stab_bad <= 1'b1;
      if (ARVALID && ARADDR !== exp_addr) stab_bad <= 1'b1;
      if (WVALID && (WDATA !== exp_wdata || WSTRB !== exp_strb)) stab_bad <= 1'b1;
    end
  end

  int errors = 0, checks = 0;
  logic [31:0] ref_mem [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic send(input bit wr, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    exp_addr = a; exp_wdata = d; exp_strb = s;
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = a; CMD_WDATA = d; CMD_WSTRB = s;
    while (!CMD_READY && n < 50) begin @(posedge ACLK); #1; n++; end
    if (!CMD_READY) check("cmd_accept_wait", CMD_READY, 1);
    @(posedge ACLK); #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!RSP_VALID && lat < 200) begin @(posedge ACLK); #1; lat++; end
    if (!RSP_VALID) check("rsp_wait", RSP_VALID, 1);
  endtask

  task automatic finish_rsp;
    RSP_READY = 1'b1;
    @(posedge ACLK); #1;
    RSP_READY = 1'b0;
  endtask

  task automatic xfer(input bit wr, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic [1:0] rs, output int lat);
    send(wr, a, d, s);
    wait_rsp(lat);
    rd = RSP_RDATA; rs = RSP_RESP;
    finish_rsp();
    if (wr) ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], d, s);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0] rs;
    int lat, a0, w0, n;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    exp_addr = '0; exp_wdata = '0; exp_strb = '0;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_cmd_ready", CMD_READY, 1);
    check("rst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, RSP_VALID}, 0);
    check("rst_rsp", {RSP_RESP, RSP_RDATA}, 0);
    check("rst_payload", {AWADDR, WDATA, WSTRB}, 0);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    xfer(1, 6'h08, 32'hDEADBEEF, 4'hF, rd, rs, lat);
    check("wr08_resp", rs, 2'b00);
    check("wr08_rdata", rd, 0);
    check("wr08_latency", lat, 4);
    check("idle_after_rsp", CMD_READY, 1);
    xfer(0, 6'h08, 0, 0, rd, rs, lat);
    check("rd08_resp", rs, 2'b00);
    check("rd08_rdata", rd, ref_mem[2]);
    check("rd08_latency", lat, 4);

    xfer(1, 6'h3C, 32'h11223344, 4'hF, rd, rs, lat);
    xfer(1, 6'h3C, 32'h000000AA, 4'b0001, rd, rs, lat);
    xfer(0, 6'h3C, 0, 0, rd, rs, lat);
    check("rd3c_strobe", rd, ref_mem[15]);

    for (int k = 0; k < 2; k++) begin
      aw_dly = k ? 3 : 0; w_dly = k ? 0 : 3;
      a0 = aw_hs; w0 = w_hs;
      xfer(1, k ? 6'h14 : 6'h10, 32'h55AA0000 | k, 4'hF, rd, rs, lat);
      check($sformatf("stall%0d_aw_hs", k), aw_hs - a0, 1);
      check($sformatf("stall%0d_w_hs", k), w_hs - w0, 1);
      check($sformatf("stall%0d_resp", k), rs, 2'b00);
      xfer(0, k ? 6'h14 : 6'h10, 0, 0, rd, rs, lat);
      check($sformatf("stall%0d_rdback", k), rd, ref_mem[k ? 5 : 4]);
    end
    aw_dly = 0; w_dly = 0;
    check("payload_stable", stab_bad, 0);

    xfer(1, 6'h00, 32'hCAFEF00D, 4'hF, rd, rs, lat);
    send(0, 6'h00, 0, 0);
    wait_rsp(lat);
    a0 = aw_hs;
    CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 6'h20; CMD_WDATA = 32'h1; CMD_WSTRB = 4'hF;
    for (int c = 0; c < 10; c++) begin
      check("hold_rsp_valid", RSP_VALID, 1);
      check("hold_rsp_rdata", RSP_RDATA, ref_mem[0]);
      check("hold_cmd_ready", CMD_READY, 0);
      @(posedge ACLK); #1;
    end
    CMD_VALID = 1'b0;
    finish_rsp();
    check("hold_no_extra_aw", aw_hs - a0, 0);

    r_en = 1'b0;
    send(0, 6'h04, 0, 0);
    n = 0;
    while (!RREADY && n < 20) begin @(posedge ACLK); #1; n++; end
    check("reach_rd_data", RREADY, 1);
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    r_en = 1'b1;
    check("abort_valids", {AWVALID, WVALID, ARVALID, RSP_VALID}, 0);
    check("abort_cmd_ready", CMD_READY, 1);
    xfer(0, 6'h04, 0, 0, rd, rs, lat);
    check("rd04_after_abort", rd, ref_mem[1]);

    for (int t = 0; t < 30; t++) begin
      automatic bit wr = 1'($urandom_range(0, 1));
      automatic logic [5:0] a = {4'($urandom_range(0, 15)), 2'b00};
      automatic logic [31:0] d = $urandom;
      automatic logic [3:0] s = 4'($urandom_range(0, 15));
      automatic logic [31:0] expd = wr ? 32'h0 : ref_mem[a[5:2]];
      slv_resp = $urandom_range(0, 1) ? 2'b10 : 2'b00;
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      xfer(wr, a, d, s, rd, rs, lat);
      check($sformatf("rand%0d_rdata", t), rd, expd);
      check($sformatf("rand%0d_resp", t), rs, slv_resp);
    end
    slv_resp = 2'b00; aw_dly = 0; w_dly = 0;
    check("rand_payload_stable", stab_bad, 0);

`ifdef M_AXIL_TIMEOUT_EN
    b_en = 1'b0;
    send(1, 6'h18, 32'h12345678, 4'hF);
    n = 0;
    while (!BREADY && n < 20) begin @(posedge ACLK); #1; n++; end
    check("reach_wr_resp", BREADY, 1);
    n = 0;
    while (!RSP_VALID && n < 100) begin @(posedge ACLK); #1; n++; end
    check("tmo_cycles", n, 16);
    check("tmo_resp", RSP_RESP, 2'b11);
    check("tmo_rdata", RSP_RDATA, 0);
    check("tmo_err", TIMEOUT_ERR, 1);
    finish_rsp();
    check("tmo_err_sticky", TIMEOUT_ERR, 1);
    b_en = 1'b1;
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    check("tmo_err_reset", TIMEOUT_ERR, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of run, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
